lcg_seed_search: RTL and testbench



---
 rtl/lcg_seed_search.sv | 198 +++++++++++++++++++
 tb/tb_lcg_seed_search.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcg_seed_search.sv
// Multi-lane LCG seed scanner: tests LANES consecutive seeds per cycle through a
// NUM_OUTPUTS-deep pipeline of modular LCG steps and reports the lowest matching seed.
module lcg_seed_search #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LANES       = 4,
  parameter int unsigned NUM_OUTPUTS = 3
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         start,
  input  logic [WIDTH-1:0]             modulus,
  input  logic [WIDTH-1:0]             multiplier,
  input  logic [WIDTH-1:0]             increment,
  input  logic [WIDTH-1:0]             seed_lo,
  input  logic [WIDTH-1:0]             seed_hi,
  input  logic [NUM_OUTPUTS*WIDTH-1:0] expected,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic                         err,
  output logic [WIDTH-1:0]             valid_seed,
  output logic [WIDTH:0]               seeds_tested
);

  typedef logic [NUM_OUTPUTS-1:0][WIDTH-1:0] vals_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]             m_r, a_r, c_r, hi_r;
  logic [NUM_OUTPUTS*WIDTH-1:0] exp_r;
  logic [WIDTH:0]               base_r, hi_ext;
  logic                         accept, issue, flush, hit_any, upstream_busy;
  logic [WIDTH-1:0]             hit_seed;
  logic [WIDTH:0]               final_cnt;
  logic [LANES-1:0]             lane_valid, iss_valid;
  logic [WIDTH-1:0]             lane_seed [LANES];
  logic [WIDTH-1:0]             iss_seed  [LANES];

  assign hi_ext = {1'b0, hi_r};
  assign flush  = RST | hit_any;
  assign busy   = (state == S_RUN) || (state == S_DRAIN);
  assign done   = (state == S_DONE);

  // Full-width product and sum so the remainder is exact.
  function automatic logic [WIDTH-1:0] lcg_step(input logic [WIDTH-1:0] v, a, c, m);
    logic [2*WIDTH:0] sum;
    sum = ({{(WIDTH+1){1'b0}}, a} * {{(WIDTH+1){1'b0}}, v}) + {{(WIDTH+1){1'b0}}, c};
    return WIDTH'(sum % {{(WIDTH+1){1'b0}}, m});
  endfunction

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_valid[l] = (base_r + (WIDTH+1)'(l)) <= hi_ext;
      lane_seed[l]  = base_r[WIDTH-1:0] + WIDTH'(l);
    end
  end

  always_ff @(posedge CLK) begin
    if (flush) iss_valid <= '0;
    else       iss_valid <= issue ? lane_valid : '0;
    for (int unsigned l = 0; l < LANES; l++) iss_seed[l] <= lane_seed[l];
  end

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_stage
    logic [LANES-1:0] in_valid, valid;
    logic [WIDTH-1:0] in_seed [LANES];
    logic [WIDTH-1:0] prev    [LANES];
    logic [WIDTH-1:0] seed    [LANES];
    vals_t            in_vals  [LANES];
    vals_t            nxt_vals [LANES];
    vals_t            vals     [LANES];
    logic             pend;  // any valid lane upstream of this stage's register

    if (k == 0) begin : g_head
      always_comb begin
        in_valid = iss_valid;
        pend     = |iss_valid;
        for (int unsigned l = 0; l < LANES; l++) begin
          in_seed[l] = iss_seed[l];
          in_vals[l] = '0;
          prev[l]    = iss_seed[l];
        end
      end
    end else begin : g_body
      always_comb begin
        in_valid = g_stage[k-1].valid;
        pend     = g_stage[k-1].pend | (|g_stage[k-1].valid);
        for (int unsigned l = 0; l < LANES; l++) begin
          in_seed[l] = g_stage[k-1].seed[l];
          in_vals[l] = g_stage[k-1].vals[l];
          prev[l]    = g_stage[k-1].vals[l][k-1];
        end
      end
    end

    always_comb begin
      for (int unsigned l = 0; l < LANES; l++) begin
        nxt_vals[l]    = in_vals[l];
        nxt_vals[l][k] = lcg_step(prev[l], a_r, c_r, m_r);
      end
    end

    always_ff @(posedge CLK) begin
      if (flush) valid <= '0;
      else       valid <= in_valid;
      for (int unsigned l = 0; l < LANES; l++) begin
        seed[l] <= in_seed[l];
        vals[l] <= nxt_vals[l];
      end
    end
  end

  assign upstream_busy = g_stage[NUM_OUTPUTS-1].pend;

  // Scan lanes high to low so the lowest matching lane is the one kept.
  always_comb begin
    hit_any   = 1'b0;
    hit_seed  = '0;
    final_cnt = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (g_stage[NUM_OUTPUTS-1].valid[LANES-1-i] &&
          (g_stage[NUM_OUTPUTS-1].vals[LANES-1-i] == exp_r)) begin
        hit_any  = 1'b1;
        hit_seed = g_stage[NUM_OUTPUTS-1].seed[LANES-1-i];
      end
      final_cnt = final_cnt + (WIDTH+1)'(g_stage[NUM_OUTPUTS-1].valid[i]);
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (hit_any || (m_r == '0) || (base_r > hi_ext)) begin
          state_nxt = S_DONE;
        end else begin
          issue = 1'b1;
          if ((base_r + (WIDTH+1)'(LANES)) > hi_ext) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hit_any || !upstream_busy) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      m_r          <= '0;
      a_r          <= '0;
      c_r          <= '0;
      hi_r         <= '0;
      exp_r        <= '0;
      base_r       <= '0;
      found        <= 1'b0;
      err          <= 1'b0;
      valid_seed   <= '0;
      seeds_tested <= '0;
    end else if (accept) begin
      m_r          <= modulus;
      a_r          <= multiplier;
      c_r          <= increment;
      hi_r         <= seed_hi;
      exp_r        <= expected;
      base_r       <= {1'b0, seed_lo};
      found        <= 1'b0;
      err          <= 1'b0;
      valid_seed   <= '0;
      seeds_tested <= '0;
    end else begin
      if (issue) base_r <= base_r + (WIDTH+1)'(LANES);
      if ((state == S_RUN) && (m_r == '0)) err <= 1'b1;
      if (busy) begin
        seeds_tested <= seeds_tested + final_cnt;
        if (hit_any) begin
          found      <= 1'b1;
          valid_seed <= hit_seed;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcg_seed_search.sv
// Bench for lcg_seed_search: table rows, control sequences and random searches
// checked against a plain seed-by-seed reference scan.
module tb_lcg_seed_search;
  localparam int unsigned W = 32;
  localparam int unsigned L = 4;
  localparam int unsigned N = 3;

  logic CLK = 1'b0;
  logic RST;
  logic start;
  logic [W-1:0] modulus, multiplier, increment, seed_lo, seed_hi;
  logic [N*W-1:0] expected;
  logic busy, done, found, err;
  logic [W-1:0] valid_seed;
  logic [W:0] seeds_tested;

  logic start8;
  logic [7:0] modulus8, multiplier8, increment8, seed_lo8, seed_hi8;
  logic [N*8-1:0] expected8;
  logic busy8, done8, found8, err8;
  logic [7:0] valid_seed8;
  logic [8:0] seeds_tested8;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 CLK = ~CLK;

  lcg_seed_search #(.WIDTH(W), .LANES(L), .NUM_OUTPUTS(N)) dut (
    .CLK(CLK), .RST(RST), .start(start), .modulus(modulus), .multiplier(multiplier),
    .increment(increment), .seed_lo(seed_lo), .seed_hi(seed_hi), .expected(expected),
    .busy(busy), .done(done), .found(found), .err(err), .valid_seed(valid_seed),
    .seeds_tested(seeds_tested));

  lcg_seed_search #(.WIDTH(8), .LANES(L), .NUM_OUTPUTS(N)) dut8 (
    .CLK(CLK), .RST(RST), .start(start8), .modulus(modulus8), .multiplier(multiplier8),
    .increment(increment8), .seed_lo(seed_lo8), .seed_hi(seed_hi8), .expected(expected8),
    .busy(busy8), .done(done8), .found(found8), .err(err8), .valid_seed(valid_seed8),
    .seeds_tested(seeds_tested8));

  typedef struct {
    logic [31:0] m, a, c, e0, e1, e2, lo, hi;
    logic        found, err;
    logic [31:0] seed;
    logic [32:0] tested;
    int unsigned done_edge;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic longint unsigned step(input longint unsigned m, a, c, v);
    return (a * v + c) % m;
  endfunction

  // Reference: walk seeds in order, first hit is the answer; timing follows from group count.
  task automatic model(input longint unsigned m, a, c, e0, e1, e2, lo, hi,
                       output bit f, output bit er, output longint unsigned seed,
                       output longint unsigned tested, output int unsigned de);
    longint unsigned v0, v1, v2, g, cnt;
    f = 0; er = 0; seed = 0; tested = 0; de = 1;
    if (m == 0) begin er = 1; return; end
    if (lo > hi) return;
    cnt = hi - lo + 1;
    for (longint unsigned s = lo; s <= hi; s++) begin
      v0 = step(m, a, c, s);
      v1 = step(m, a, c, v0);
      v2 = step(m, a, c, v1);
      if (v0 == e0 && v1 == e1 && v2 == e2) begin
        g = (s - lo) / L + 1;
        f = 1;
        seed = s;
        tested = (g * L > cnt) ? cnt : g * L;
        de = int'(g) + N + 1;
        return;
      end
    end
    g = (cnt + L - 1) / L;
    tested = cnt;
    de = int'(g) + N + 1;
  endtask

  task automatic run_search(input logic [31:0] m_i, a_i, c_i, e0, e1, e2, lo_i, hi_i,
                            input int unsigned pulse_at, output int unsigned de,
                            output logic b0, output logic d0, output logic f0,
                            output logic [W:0] st0);
    @(negedge CLK);
    modulus = m_i; multiplier = a_i; increment = c_i;
    expected = {e2, e1, e0}; seed_lo = lo_i; seed_hi = hi_i; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    b0 = busy; d0 = done; f0 = found; st0 = seeds_tested;
    modulus = $urandom; multiplier = $urandom; increment = $urandom;
    expected = {$urandom, $urandom, $urandom}; seed_lo = $urandom; seed_hi = $urandom;
    de = 0;
    for (int unsigned e = 1; e <= 500; e++) begin
      @(posedge CLK); #1;
      if (done) begin de = e; break; end
      start = (e == pulse_at);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int unsigned de, input bit f, input bit er,
                              input longint unsigned seed, input longint unsigned tested,
                              input int unsigned want_de);
    chk({tag, " done_edge"}, de, want_de);
    chk({tag, " found"}, found, f);
    chk({tag, " err"}, err, er);
    chk({tag, " valid_seed"}, valid_seed, seed);
    chk({tag, " seeds_tested"}, seeds_tested, tested);
    chk({tag, " busy_at_done"}, busy, 0);
  endtask

  task automatic run8(input logic [7:0] m_i, a_i, c_i, e0, e1, e2, lo_i, hi_i,
                      output int unsigned de);
    @(negedge CLK);
    modulus8 = m_i; multiplier8 = a_i; increment8 = c_i;
    expected8 = {e2, e1, e0}; seed_lo8 = lo_i; seed_hi8 = hi_i; start8 = 1'b1;
    @(posedge CLK); #1;
    start8 = 1'b0;
    de = 0;
    for (int unsigned e = 1; e <= 500; e++) begin
      @(posedge CLK); #1;
      if (done8) begin de = e; break; end
    end
  endtask

  initial begin
    int unsigned de, mde;
    logic b0, d0, f0;
    logic [W:0] st0;
    bit mf, mer;
    longint unsigned mseed, mtested, lo, hi, m, a, c, e0, e1, e2, s;

    tbl[0] = '{32'd993441, 32'd4001, 32'd60211, 32'd444307, 32'd466569, 32'd127141,
               32'd0, 32'd1000, 1'b1, 1'b0, 32'd96, 33'd100, 29};
    tbl[1] = '{32'd993441, 32'd4001, 32'd60211, 32'd0, 32'd466569, 32'd127141,
               32'd0, 32'd99, 1'b0, 1'b0, 32'd0, 33'd100, 29};
    tbl[2] = '{32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0,
               32'd0, 32'd7, 1'b1, 1'b0, 32'd0, 33'd4, 5};
    tbl[3] = '{32'd2, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0,
               32'd10, 32'd12, 1'b0, 1'b0, 32'd0, 33'd3, 5};
    tbl[4] = '{32'd0, 32'd4001, 32'd60211, 32'd1, 32'd2, 32'd3,
               32'd0, 32'd100, 1'b0, 1'b1, 32'd0, 33'd0, 1};
    tbl[5] = '{32'd993441, 32'd4001, 32'd60211, 32'd444307, 32'd466569, 32'd127141,
               32'd5, 32'd4, 1'b0, 1'b0, 32'd0, 33'd0, 1};

    RST = 1'b1; start = 1'b0; start8 = 1'b0;
    modulus = '0; multiplier = '0; increment = '0; seed_lo = '0; seed_hi = '0; expected = '0;
    modulus8 = '0; multiplier8 = '0; increment8 = '0; seed_lo8 = '0; seed_hi8 = '0; expected8 = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset found", found, 0);
    chk("reset err", err, 0);
    chk("reset valid_seed", valid_seed, 0);
    chk("reset seeds_tested", seeds_tested, 0);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_search(tbl[i].m, tbl[i].a, tbl[i].c, tbl[i].e0, tbl[i].e1, tbl[i].e2,
                 tbl[i].lo, tbl[i].hi, 0, de, b0, d0, f0, st0);
      chk($sformatf("row%0d done_after_start", i), d0, 0);
      if (tbl[i].done_edge > 1) chk($sformatf("row%0d busy_after_start", i), b0, 1);
      check_result($sformatf("row%0d", i), de, tbl[i].found, tbl[i].err, tbl[i].seed,
                   tbl[i].tested, tbl[i].done_edge);
    end

    // Restart from DONE with found=1 must clear results and reproduce the run.
    run_search(tbl[0].m, tbl[0].a, tbl[0].c, tbl[0].e0, tbl[0].e1, tbl[0].e2,
               tbl[0].lo, tbl[0].hi, 0, de, b0, d0, f0, st0);
    run_search(tbl[0].m, tbl[0].a, tbl[0].c, tbl[0].e0, tbl[0].e1, tbl[0].e2,
               tbl[0].lo, tbl[0].hi, 0, de, b0, d0, f0, st0);
    chk("restart busy", b0, 1);
    chk("restart done_cleared", d0, 0);
    chk("restart found_cleared", f0, 0);
    chk("restart tested_cleared", st0, 0);
    check_result("restart", de, 1, 0, 96, 100, 29);

    // start pulsed mid-run with scrambled config is ignored.
    run_search(tbl[0].m, tbl[0].a, tbl[0].c, tbl[0].e0, tbl[0].e1, tbl[0].e2,
               tbl[0].lo, tbl[0].hi, 5, de, b0, d0, f0, st0);
    check_result("midstart", de, 1, 0, 96, 100, 29);

    // Reset in the middle of a run.
    @(negedge CLK);
    modulus = tbl[0].m; multiplier = tbl[0].a; increment = tbl[0].c;
    expected = {tbl[0].e2, tbl[0].e1, tbl[0].e0}; seed_lo = tbl[0].lo; seed_hi = tbl[0].hi;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    #1;
    chk("rstrun tested_edge9", seeds_tested, 20);
    chk("rstrun busy_edge9", busy, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("rstrun busy", busy, 0);
    chk("rstrun done", done, 0);
    chk("rstrun found", found, 0);
    chk("rstrun err", err, 0);
    chk("rstrun valid_seed", valid_seed, 0);
    chk("rstrun seeds_tested", seeds_tested, 0);
    RST = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    chk("rstrun idle_done", done, 0);
    chk("rstrun idle_busy", busy, 0);
    chk("rstrun idle_tested", seeds_tested, 0);
    run_search(tbl[0].m, tbl[0].a, tbl[0].c, tbl[0].e0, tbl[0].e1, tbl[0].e2,
               tbl[0].lo, tbl[0].hi, 0, de, b0, d0, f0, st0);
    check_result("after_rst", de, 1, 0, 96, 100, 29);

    // Random searches against the reference scan.
    for (int it = 0; it < 16; it++) begin
      lo = (it % 4 == 3) ? 64'hFFFF_FFFF - $urandom_range(0, 40) : 64'($urandom);
      hi = lo + $urandom_range(0, 150);
      if (hi > 64'hFFFF_FFFF) hi = 64'hFFFF_FFFF;
      m = (it % 3 == 0) ? 64'($urandom_range(1, 40)) : 64'($urandom);
      if (m == 0) m = 1;
      a = $urandom; c = $urandom;
      if (it % 2 == 0) begin
        s = lo + $urandom_range(0, int'(hi - lo));
        e0 = step(m, a, c, s); e1 = step(m, a, c, e0); e2 = step(m, a, c, e1);
      end else begin
        e0 = $urandom; e1 = $urandom; e2 = $urandom;
      end
      model(m, a, c, e0, e1, e2, lo, hi, mf, mer, mseed, mtested, mde);
      run_search(32'(m), 32'(a), 32'(c), 32'(e0), 32'(e1), 32'(e2), 32'(lo), 32'(hi),
                 0, de, b0, d0, f0, st0);
      check_result($sformatf("rand%0d", it), de, mf, mer, mseed, mtested, mde);
    end

    // WIDTH=8 instance: full range up to 2^8-1 must not wrap.
    run8(8'd200, 8'd37, 8'd11, 8'd255, 8'd255, 8'd255, 8'd0, 8'd255, de);
    chk("w8 full done_edge", de, 68);
    chk("w8 full found", found8, 0);
    chk("w8 full seeds_tested", seeds_tested8, 256);
    chk("w8 full busy", busy8, 0);
    run8(8'd251, 8'd1, 8'd0, 8'd250, 8'd250, 8'd250, 8'd0, 8'd255, de);
    chk("w8 top done_edge", de, 67);
    chk("w8 top found", found8, 1);
    chk("w8 top valid_seed", valid_seed8, 250);
    chk("w8 top seeds_tested", seeds_tested8, 252);
    chk("w8 top err", err8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
